// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and defaults for the pipeline-to-memory arbiter.
package cpu_mem_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} arb_state_t;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: bus-timeout down-counter, pulses in the TIMEOUT-th enabled cycle after clear; TIMEOUT=0 disables it.
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    logic [TW-1:0] r_cnt;
    // load on entry to BUSY so the first BUSY cycle already counts as one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (i_clr) r_cnt <= LOAD;
        else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_timeout = (TIMEOUT != 0) && i_en && (r_cnt == '0);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter of one memory port between fetch and data; data has priority, fetch gets a turn after a data burst when MEM_ARB_FAIRNESS_EN is defined.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
`ifdef MEM_ARB_FAIRNESS_EN
    parameter int DATA_BURST_MAX = 4,
`endif
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);
    arb_state_t r_state, w_next;
    logic r_own;
    logic w_data_win, w_grant_d, w_grant_i, w_busy, w_done, w_timeout;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [3:0] r_burst;
    assign w_data_win = d_req && !(i_req && r_burst >= 4'(DATA_BURST_MAX));
    // count data grants that made fetch wait; any grant without a waiting fetch restarts the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_burst <= '0;
        else if (w_grant_i || (w_grant_d && !i_req)) r_burst <= '0;
        else if (w_grant_d) r_burst <= r_burst + 1'b1;
    end
`else
    assign w_data_win = d_req;
`endif

    assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign w_grant_d = (r_state == IDLE) && w_data_win;
    assign w_grant_i = (r_state == IDLE) && !w_data_win && i_req;
    assign w_done    = w_busy && (mem_ack || w_timeout);

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_grant_d || w_grant_i),
        .i_en      (w_busy),
        .o_timeout (w_timeout)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next state: grant from IDLE, finish BUSY on ack or timeout, DONE always returns to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:           w_next = w_grant_d ? BUSY_D : (w_grant_i ? BUSY_I : IDLE);
            BUSY_I, BUSY_D: w_next = w_done ? DONE : r_state;
            default:        w_next = IDLE;
        endcase
    end

    // registered bus outputs, request latches and completion pulses; ack wins over a same-cycle timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_own     <= OWN_I;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            mem_req <= w_grant_d || w_grant_i || (w_busy && !w_done);
            i_ack   <= w_done && (r_own == OWN_I);
            d_ack   <= w_done && (r_own == OWN_D);
            err     <= w_done && !mem_ack;
            if (w_grant_d) begin
                r_own     <= OWN_D;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_own    <= OWN_I;
                mem_we   <= 1'b0;
                mem_addr <= i_addr;
            end else if (w_done) begin
                mem_we <= 1'b0;
            end
            if (w_done && r_own == OWN_I) i_rdata <= mem_ack ? mem_rdata : '0;
            if (w_done && r_own == OWN_D) d_rdata <= mem_ack ? mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for slow memory, timeout, reset abort and fairness.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic i_ack, d_ack, err, mem_req, mem_we;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
`ifdef MEM_ARB_FAIRNESS_EN
        .DATA_BURST_MAX(4),
`endif
        .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic ir; logic [15:0] ia;
        logic dr; logic dw; logic [15:0] da; logic [15:0] dd;
        logic ma; logic [15:0] md;
        logic mr; logic mw; logic [15:0] maddr; logic [15:0] mwd;
        logic ik; logic [15:0] ird;
        logic dk; logic [15:0] drd;
        logic er;
    } vec_t;

    vec_t vt[16];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int nd, ni, na;
        logic [4:0] ord;
        // fetch read, store/fetch collision, data load, stray mem_ack while idle
        vt[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[1]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[2]  = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,       1'b0, 1'b0, 16'h0, 16'h0,    1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b0};
        vt[3]  = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,       1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[4]  = '{1'b1, 16'h0020, 1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[5]  = '{1'b1, 16'h0020, 1'b1, 1'b1, 16'h0040, 16'h1234, 1'b1, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[6]  = '{1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0, 1'b1, 16'h0000, 1'b0};
        vt[7]  = '{1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[8]  = '{1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h5A5A, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[9]  = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,       1'b0, 1'b0, 16'h0, 16'h0,    1'b1, 16'h5A5A, 1'b0, 16'h0, 1'b0};
        vt[10] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,       1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[11] = '{1'b0, 16'h0, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[12] = '{1'b0, 16'h0, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b1, 16'hC0DE, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[13] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,       1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0, 1'b1, 16'hC0DE, 1'b0};
        vt[14] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFF,    1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        vt[15] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,       1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0, 1'b0, 16'h0, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        smp();
        chk1("rst mem_req", mem_req, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk16("rst mem_addr", mem_addr, 16'h0);
        chk16("rst mem_wdata", mem_wdata, 16'h0);
        chk1("rst i_ack", i_ack, 1'b0);
        chk1("rst d_ack", d_ack, 1'b0);
        chk1("rst err", err, 1'b0);
        chk16("rst i_rdata", i_rdata, 16'h0);
        chk16("rst d_rdata", d_rdata, 16'h0);
        tick();
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            tick();
            i_req = vt[k].ir; i_addr = vt[k].ia;
            d_req = vt[k].dr; d_we = vt[k].dw; d_addr = vt[k].da; d_wdata = vt[k].dd;
            mem_ack = vt[k].ma; mem_rdata = vt[k].md;
            smp();
            chk1($sformatf("v%0d mem_req", k), mem_req, vt[k].mr);
            chk1($sformatf("v%0d i_ack", k), i_ack, vt[k].ik);
            chk1($sformatf("v%0d d_ack", k), d_ack, vt[k].dk);
            chk1($sformatf("v%0d err", k), err, vt[k].er);
            if (vt[k].mr) begin
                chk1($sformatf("v%0d mem_we", k), mem_we, vt[k].mw);
                chk16($sformatf("v%0d mem_addr", k), mem_addr, vt[k].maddr);
            end
            if (vt[k].mr && vt[k].mw) chk16($sformatf("v%0d mem_wdata", k), mem_wdata, vt[k].mwd);
            if (vt[k].ik) chk16($sformatf("v%0d i_rdata", k), i_rdata, vt[k].ird);
            if (vt[k].dk) chk16($sformatf("v%0d d_rdata", k), d_rdata, vt[k].drd);
        end

        // slow memory: ack in the 5th BUSY cycle
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'hAAAA;
        smp();
        for (int b = 1; b <= 5; b++) begin
            tick();
            if (b == 5) begin mem_ack = 1'b1; mem_rdata = 16'h7777; end
            smp();
            chk1($sformatf("slow b%0d mem_req", b), mem_req, 1'b1);
            chk16($sformatf("slow b%0d mem_addr", b), mem_addr, 16'h0100);
            chk16($sformatf("slow b%0d mem_wdata", b), mem_wdata, 16'hAAAA);
            chk1($sformatf("slow b%0d d_ack", b), d_ack, 1'b0);
        end
        tick();
        d_req = 1'b0; mem_ack = 1'b0;
        smp();
        chk1("slow d_ack", d_ack, 1'b1);
        chk1("slow err", err, 1'b0);
        chk16("slow d_rdata", d_rdata, 16'h7777);
        chk1("slow mem_req off", mem_req, 1'b0);

        // timeout: no ack for 8 BUSY cycles, then a late ack is ignored
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        smp();
        for (int b = 1; b <= 8; b++) begin
            tick();
            smp();
            chk1($sformatf("to b%0d mem_req", b), mem_req, 1'b1);
            chk1($sformatf("to b%0d d_ack", b), d_ack, 1'b0);
        end
        tick();
        d_req = 1'b0;
        smp();
        chk1("to d_ack", d_ack, 1'b1);
        chk1("to err", err, 1'b1);
        chk16("to d_rdata", d_rdata, 16'h0);
        chk1("to mem_req off", mem_req, 1'b0);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        smp();
        chk1("late ack d_ack", d_ack, 1'b0);
        chk1("late ack err", err, 1'b0);
        tick();
        mem_ack = 1'b0;
        smp();
        chk1("after late d_ack", d_ack, 1'b0);
        chk1("after late i_ack", i_ack, 1'b0);
        chk1("after late mem_req", mem_req, 1'b0);

        // ack in the same cycle as the timeout limit completes normally
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0210;
        smp();
        for (int b = 1; b <= 8; b++) begin
            tick();
            if (b == 8) begin mem_ack = 1'b1; mem_rdata = 16'h1111; end
            smp();
            chk1($sformatf("lim b%0d mem_req", b), mem_req, 1'b1);
        end
        tick();
        d_req = 1'b0; mem_ack = 1'b0;
        smp();
        chk1("lim d_ack", d_ack, 1'b1);
        chk1("lim err", err, 1'b0);
        chk16("lim d_rdata", d_rdata, 16'h1111);

        // reset while BUSY_D aborts at once, then a new request completes
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0500; d_wdata = 16'h5555;
        tick();
        #2;
        chk1("rb mem_req busy", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rb mem_req async", mem_req, 1'b0);
        tick();
        rst = 1'b0; d_req = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tick();
            smp();
            chk1($sformatf("rb c%0d d_ack", b), d_ack, 1'b0);
            chk1($sformatf("rb c%0d mem_req", b), mem_req, 1'b0);
        end
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0600;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h2222;
        smp();
        chk1("rb2 mem_req", mem_req, 1'b1);
        chk16("rb2 mem_addr", mem_addr, 16'h0600);
        tick();
        d_req = 1'b0; mem_ack = 1'b0;
        smp();
        chk1("rb2 d_ack", d_ack, 1'b1);
        chk16("rb2 d_rdata", d_rdata, 16'h2222);
        chk1("rb2 err", err, 1'b0);
        tick();

        // both requests held with a single-cycle memory for 30 cycles
        nd = 0; ni = 0; na = 0; ord = '0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (n == 0) begin
                d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'h3333;
                i_req = 1'b1; i_addr = 16'h0400;
            end
            mem_ack = mem_req;
            smp();
            if (d_ack) nd++;
            if (i_ack) ni++;
            if ((d_ack || i_ack) && na < 5) begin
                ord[na] = d_ack;
                na++;
            end
        end
        tick();
        d_req = 1'b0; i_req = 1'b0; mem_ack = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
        chk16("fair data acks", 16'(nd), 16'd8);
        chk16("fair fetch acks", 16'(ni), 16'd2);
        chk16("fair order", {11'h0, ord}, 16'h000F);
`else
        chk16("strict data acks", 16'(nd), 16'd10);
        chk16("strict fetch acks", 16'(ni), 16'd0);
        chk16("strict order", {11'h0, ord}, 16'h001F);
`endif
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
